// File: rtl/prog_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_ctrl_pkg
// Description : Shared definitions for the program load / run / register dump
//               controller: controller state encoding and the default values
//               of the controller parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_ctrl_pkg;

    // Default parameter values
    localparam int c_IMEM_BYTES = 256;   // instruction memory capacity in bytes
    localparam int c_RUN_CYCLES = 4500;  // clk cycles the processor is enabled
    localparam int c_DUMP_FIRST = 16;    // first register dumped (inclusive)
    localparam int c_DUMP_LAST  = 23;    // last register dumped (inclusive)

    // Controller states
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_WR0  = 4'd2,
        S_WR1  = 4'd3,
        S_WR2  = 4'd4,
        S_WR3  = 4'd5,
        S_RUN  = 4'd6,
        S_DSET = 4'd7,
        S_DOUT = 4'd8,
        S_DONE = 4'd9
    } state_e;

endpackage
`default_nettype wire

// File: rtl/word_byte_ser.sv
`default_nettype none
// ============================================================================
// Module      : word_byte_ser
// Description : Serialises one 32-bit word into four big-endian byte strobe
//               cycles (MSB first). Each byte carries its memory address; the
//               write enable is suppressed for addresses beyond IMEM_BYTES.
// Ports       : clk, rst_n      - clock, async active-low reset
//               load_i          - capture word_i / addr_i, start 4 strobes
//               word_i, addr_i  - word to split, address of its first byte
//               strobe_o        - a byte slot is active this cycle
//               we_o            - slot is active and its address is in range
//               byte_o, addr_o  - current byte and its address
// Revision    : 1.0 - initial release
// ============================================================================
module word_byte_ser
    import prog_ctrl_pkg::*;
#(
    parameter int IMEM_BYTES = c_IMEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic [31:0] addr_i,
    output logic        strobe_o,
    output logic        we_o,
    output logic [7:0]  byte_o,
    output logic [31:0] addr_o
);

    localparam logic [31:0] c_LIMIT = 32'(IMEM_BYTES);

    logic [31:0] word_q;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [1:0]  slot_q;
    logic [1:0]  slot_d;
    logic        strobe_q;
    logic        we_q;
    logic [7:0]  byte_q;

    // Byte slot s of a word, slot 0 being the most significant byte
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] s);
        logic [7:0] b;
        case (s)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    always_comb begin
        slot_d = slot_q + 2'd1;
        addr_d = addr_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            addr_q   <= '0;
            slot_q   <= '0;
            strobe_q <= 1'b0;
            we_q     <= 1'b0;
            byte_q   <= '0;
        end else if (load_i) begin
            // The first byte is presented in the cycle right after the load
            word_q   <= word_i;
            addr_q   <= addr_i;
            slot_q   <= 2'd0;
            strobe_q <= 1'b1;
            we_q     <= (addr_i < c_LIMIT);
            byte_q   <= word_i[31:24];
        end else if (strobe_q) begin
            if (slot_q == 2'd3) begin
                strobe_q <= 1'b0;
                we_q     <= 1'b0;
            end else begin
                slot_q <= slot_d;
                addr_q <= addr_d;
                we_q   <= (addr_d < c_LIMIT);
                byte_q <= pick_byte(word_q, slot_d);
            end
        end
    end

    assign strobe_o = strobe_q;
    assign we_o     = we_q;
    assign byte_o   = byte_q;
    assign addr_o   = addr_q;

endmodule
`default_nettype wire

// File: rtl/prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prog_run_ctrl
// Description : Host-to-processor program controller. Accepts 32-bit program
//               words, writes them byte-wise into instruction memory, runs the
//               processor for RUN_CYCLES cycles, then dumps registers
//               DUMP_FIRST..DUMP_LAST over a valid/ready stream.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               in_valid/in_ready/in_data/in_last - program word stream
//               write_data/write_address/We - instruction memory byte port
//               pc_enable                   - processor run enable
//               reg_file_address/reg_file_data - register debug read port
//               out_valid/out_ready/out_data/out_index - register dump stream
//               start, done                 - restart from DONE, dump finished
//               overflow                    - sticky: byte beyond IMEM_BYTES
// Revision    : 1.0 - initial release
// ============================================================================
module prog_run_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int IMEM_BYTES = c_IMEM_BYTES,
    parameter int RUN_CYCLES = c_RUN_CYCLES,
    parameter int DUMP_FIRST = c_DUMP_FIRST,
    parameter int DUMP_LAST  = c_DUMP_LAST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [7:0]  write_data,
    output logic [31:0] write_address,
    output logic        We,
    output logic        pc_enable,
    output logic [4:0]  reg_file_address,
    input  logic [31:0] reg_file_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    input  logic        start,
    output logic        done,
    output logic        overflow
);

    localparam logic [4:0]  c_IDX_FIRST = 5'(DUMP_FIRST);
    localparam logic [4:0]  c_IDX_LAST  = 5'(DUMP_LAST);
    localparam logic [31:0] c_RUN_LAST  = 32'(RUN_CYCLES - 1);

    state_e      state_q;
    logic        last_q;
    logic        in_ready_q;
    logic        pc_enable_q;
    logic [31:0] run_cnt_q;
    logic [31:0] byte_cnt_q;
    logic [31:0] byte_cnt_d;
    logic [4:0]  idx_q;
    logic [4:0]  rfa_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [4:0]  out_index_q;
    logic        done_q;
    logic        overflow_q;

    logic        w_accept;
    logic        w_ser_strobe;
    logic        w_ser_we;

    assign w_accept = in_valid && in_ready_q;

    // The serializer's strobe runs exactly during WR0..WR3, so the byte
    // counter and the serializer's address advance in lock step.
    word_byte_ser #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_accept),
        .word_i   (in_data),
        .addr_i   (byte_cnt_q),
        .strobe_o (w_ser_strobe),
        .we_o     (w_ser_we),
        .byte_o   (write_data),
        .addr_o   (write_address)
    );

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (w_ser_strobe) begin
            byte_cnt_d = byte_cnt_q + 32'd1;
        end else if ((state_q == S_DONE) && start) begin
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            pc_enable_q <= 1'b0;
            run_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            idx_q       <= c_IDX_FIRST;
            rfa_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;

            // A strobed byte without write enable fell outside the memory
            if (w_ser_strobe && !w_ser_we) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        state_q    <= S_WR0;
                        last_q     <= in_last;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_WR0: state_q <= S_WR1;
                S_WR1: state_q <= S_WR2;
                S_WR2: state_q <= S_WR3;
                S_WR3: begin
                    if (!last_q) begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                    end else if (RUN_CYCLES == 0) begin
                        state_q <= S_DSET;
                        rfa_q   <= idx_q;
                    end else begin
                        state_q     <= S_RUN;
                        pc_enable_q <= 1'b1;
                        run_cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (run_cnt_q == c_RUN_LAST) begin
                        state_q     <= S_DSET;
                        pc_enable_q <= 1'b0;
                        rfa_q       <= idx_q;
                    end else begin
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end
                end
                S_DSET: begin
                    // reg_file_data answers the address presented this cycle
                    state_q     <= S_DOUT;
                    out_data_q  <= reg_file_data;
                    out_index_q <= idx_q;
                    out_valid_q <= 1'b1;
                end
                S_DOUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == c_IDX_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            idx_q   <= c_IDX_FIRST;
                        end else begin
                            state_q <= S_DSET;
                            idx_q   <= idx_q + 5'd1;
                            rfa_q   <= idx_q + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q    <= S_IDLE;
                        done_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready         = in_ready_q;
    assign We               = w_ser_we;
    assign pc_enable        = pc_enable_q;
    assign reg_file_address = rfa_q;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_index        = out_index_q;
    assign done             = done_q;
    assign overflow         = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_run_ctrl
// Description : Self-checking bench for prog_run_ctrl. A main instance uses
//               the default parameters; a second instance has a 4-byte
//               memory and no run phase. Expected byte streams, run length
//               and dump contents come from a behavioural model of the
//               controller's rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_run_ctrl;

    localparam int IMEM   = 256;
    localparam int RUNC   = 4500;
    localparam int DF     = 16;
    localparam int DL     = 23;
    localparam int B_IMEM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance ----------------
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, start = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, We, pc_enable, out_valid, done, overflow;
    logic [7:0]  write_data;
    logic [31:0] write_address, out_data, reg_file_data;
    logic [4:0]  reg_file_address, out_index;
    logic [31:0] rf [32];

    always_comb reg_file_data = rf[reg_file_address];

    prog_run_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .write_data(write_data), .write_address(write_address), .We(We),
        .pc_enable(pc_enable), .reg_file_address(reg_file_address), .reg_file_data(reg_file_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .start(start), .done(done), .overflow(overflow)
    );

    // ---------------- small instance ----------------
    logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1, b_start = 1'b0;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_We, b_pc_enable, b_out_valid, b_done, b_overflow;
    logic [7:0]  b_write_data;
    logic [31:0] b_write_address, b_out_data, b_reg_file_data;
    logic [4:0]  b_reg_file_address, b_out_index;

    always_comb b_reg_file_data = 32'h100 + {27'd0, b_reg_file_address};

    prog_run_ctrl #(.IMEM_BYTES(B_IMEM), .RUN_CYCLES(0), .DUMP_FIRST(DF), .DUMP_LAST(DL)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .write_data(b_write_data), .write_address(b_write_address), .We(b_We),
        .pc_enable(b_pc_enable), .reg_file_address(b_reg_file_address), .reg_file_data(b_reg_file_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_index(b_out_index),
        .start(b_start), .done(b_done), .overflow(b_overflow)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    int          cyc = 0;
    logic [39:0] got_wr[$];
    int          wr_cyc[$];
    logic [36:0] got_x[$];
    int          x_cyc[$];
    int          acc_cyc[$];
    int          pc_cnt = 0, pc_seg = 0, pc_first = 0;
    logic        pc_prev = 1'b0;
    logic        st_v = 1'b0, st_r = 1'b0;
    logic [31:0] st_d = '0;
    logic [4:0]  st_i = '0;
    logic [39:0] b_wr[$];
    logic [36:0] b_x[$];
    int          b_pc = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            st_v    = 1'b0;
            pc_prev = 1'b0;
        end else begin
            if (We) begin
                got_wr.push_back({write_address, write_data});
                wr_cyc.push_back(cyc);
            end
            if (pc_enable && !pc_prev) begin
                pc_seg++;
                pc_first = cyc;
            end
            if (pc_enable) pc_cnt++;
            pc_prev = pc_enable;
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (st_v && !st_r) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, st_d);
                check("hold_index", out_index, st_i);
            end
            if (out_valid && out_ready) begin
                got_x.push_back({out_index, out_data});
                x_cyc.push_back(cyc);
            end
            st_v = out_valid;
            st_r = out_ready;
            st_d = out_data;
            st_i = out_index;
            if (b_We) b_wr.push_back({b_write_address, b_write_data});
            if (b_pc_enable) b_pc++;
            if (b_out_valid && b_out_ready) b_x.push_back({b_out_index, b_out_data});
        end
    end

    // ---------------- out_ready driver ----------------
    int bp_mode = 0;  // 0: always ready, 1: random, 2: held low
    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- reference model ----------------
    logic [39:0] exp_wr[$];
    int          mcnt = 0;
    bit          exp_ovf = 1'b0;

    // Every word yields four bytes, MSB first, at consecutive addresses;
    // only addresses inside the memory produce a write.
    task automatic model_load(input logic [31:0] w[$], input int lim);
        for (int i = 0; i < w.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b = 8'((w[i] >> (24 - 8 * k)) & 32'hFF);
                if (mcnt < lim) exp_wr.push_back({32'(mcnt), b});
                else            exp_ovf = 1'b1;
                mcnt++;
            end
        end
    endtask

    task automatic clr();
        got_wr.delete(); wr_cyc.delete(); got_x.delete(); x_cyc.delete();
        acc_cyc.delete(); exp_wr.delete();
        pc_cnt = 0; pc_seg = 0; pc_first = 0;
    endtask

    task automatic cmp_wr(input string tag);
        check({tag, "_count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check(tag, got_wr[i], exp_wr[i]);
    endtask

    task automatic cmp_dump(input string tag, input bit spacing);
        check({tag, "_count"}, got_x.size(), DL - DF + 1);
        for (int i = 0; i < got_x.size() && i <= DL - DF; i++) begin
            check(tag, got_x[i], {5'(DF + i), rf[DF + i]});
            if (spacing && i > 0) check({tag, "_spacing"}, x_cyc[i] - x_cyc[i-1], 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] w[$], input bit gaps);
        for (int i = 0; i < w.size(); i++) begin
            int tries;
            bit acc;
            tries = 0;
            acc   = 1'b0;
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = (i == w.size() - 1);
            while (!acc && tries < 40) begin
                @(negedge clk);
                acc = in_ready;
                tick();
                tries++;
            end
            check("load_accept", acc, 1);
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
        tick();
    endtask

    task automatic wait_out_valid(input string tag, input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, out_valid, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_in_ready", in_ready, 1);
        check("start_done_clear", done, 0);
        tick();
    endtask

    task automatic rand_words(output logic [31:0] w[$], input int n);
        w.delete();
        for (int i = 0; i < n; i++) w.push_back($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] words[$];
        int n;

        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", We, 0);
        check("rst_write_data", write_data, 0);
        check("rst_write_address", write_address, 0);
        check("rst_pc_enable", pc_enable, 0);
        check("rst_rf_addr", reg_file_address, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        check("in_ready_after_edge", in_ready, 1);
        tick();

        // Single word program, register model 0x100+addr, always ready
        clr(); mcnt = 0; exp_ovf = 1'b0;
        words = '{32'h8C100004};
        model_load(words, IMEM);
        load(words, 1'b0);
        wait_done("t1_done", RUNC + 500);
        cmp_wr("t1_wr");
        check("t1_wr_consecutive", wr_cyc[wr_cyc.size()-1] - wr_cyc[0], 3);
        check("t1_pc_cycles", pc_cnt, RUNC);
        check("t1_pc_segments", pc_seg, 1);
        check("t1_run_after_last_byte", pc_first, wr_cyc[wr_cyc.size()-1] + 1);
        cmp_dump("t1_dump", 1'b1);
        check("t1_overflow", overflow, 0);
        pulse_start();

        // Three random words with in_valid held, dump under back-pressure
        clr(); mcnt = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rand_words(words, 3);
        model_load(words, IMEM);
        bp_mode = 2;
        load(words, 1'b0);
        check("t2_accept_count", acc_cyc.size(), 3);
        check("t2_accept_gap0", acc_cyc[1] - acc_cyc[0], 5);
        check("t2_accept_gap1", acc_cyc[2] - acc_cyc[1], 5);
        wait_out_valid("t2_first_valid", RUNC + 200);
        repeat (5) @(negedge clk);
        tick();
        bp_mode = 1;
        wait_done("t2_done", 400);
        bp_mode = 0;
        cmp_wr("t2_wr");
        check("t2_pc_cycles", pc_cnt, RUNC);
        check("t2_run_after_last_byte", pc_first, wr_cyc[wr_cyc.size()-1] + 1);
        cmp_dump("t2_dump", 1'b0);
        pulse_start();

        // Reset in the middle of a word's byte writes
        clr();
        rand_words(words, 1);
        load(words, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midload_we", We, 0);
        check("midload_in_ready", in_ready, 0);
        got_wr.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("midload_no_more_we", got_wr.size(), 0);
        @(negedge clk);
        check("midload_in_ready_back", in_ready, 1);
        tick();

        // Reset during run cycle 100, then reload from address 0
        clr(); mcnt = 0;
        rand_words(words, 1);
        load(words, 1'b0);
        n = 0;
        while (pc_cnt < 100 && n < RUNC) begin
            @(negedge clk);
            n++;
        end
        check("midrun_reached", pc_cnt, 100);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_pc_async", pc_enable, 0);
        check("midrun_in_ready", in_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("midrun_in_ready_back", in_ready, 1);
        tick();
        clr(); mcnt = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rand_words(words, 2);
        model_load(words, IMEM);
        bp_mode = 2;
        load(words, 1'b0);
        wait_out_valid("t4_first_valid", RUNC + 200);
        cmp_wr("t4_wr");
        check("t4_pc_cycles", pc_cnt, RUNC);
        check("t4_dump_data", out_data, rf[DF]);
        check("t4_dump_index", out_index, DF);
        // Reset while a dump word is waiting
        #2 rst_n = 1'b0;
        #1;
        check("middump_out_valid", out_valid, 0);
        check("middump_out_data", out_data, 0);
        check("middump_rf_addr", reg_file_address, 0);
        bp_mode = 0;
        got_x.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("middump_no_more_valid", got_x.size(), 0);

        // Program larger than the memory: overflow
        clr(); mcnt = 0; exp_ovf = 1'b0;
        rand_words(words, IMEM / 4 + 1);
        model_load(words, IMEM);
        load(words, 1'b1);
        wait_done("t6_done", RUNC + 500);
        cmp_wr("t6_wr");
        check("t6_overflow", overflow, exp_ovf);
        pulse_start();
        repeat (3) tick();
        check("t6_overflow_sticky", overflow, 1);

        // Small instance: 4-byte memory, no run phase
        mcnt = 0; exp_ovf = 1'b0; exp_wr.delete();
        rand_words(words, 2);
        model_load(words, B_IMEM);
        for (int i = 0; i < 2; i++) begin
            bit acc;
            acc = 1'b0;
            n = 0;
            b_in_valid = 1'b1;
            b_in_data  = words[i];
            b_in_last  = (i == 1);
            while (!acc && n < 40) begin
                @(negedge clk);
                acc = b_in_ready;
                tick();
                n++;
            end
            check("b_load_accept", acc, 1);
        end
        b_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (b_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b_done", b_done, 1);
        check("b_we_count", b_wr.size(), exp_wr.size());
        for (int i = 0; i < b_wr.size() && i < exp_wr.size(); i++)
            check("b_wr", b_wr[i], exp_wr[i]);
        check("b_overflow", b_overflow, exp_ovf);
        check("b_pc_never", b_pc, 0);
        check("b_dump_count", b_x.size(), DL - DF + 1);
        for (int i = 0; i < b_x.size() && i <= DL - DF; i++)
            check("b_dump", b_x[i], {5'(DF + i), 32'h100 + 32'(DF + i)});
        repeat (3) tick();
        check("b_overflow_sticky", b_overflow, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
